i2c_reg_target: RTL and testbench

- I2C/SCCB target (responder) with an internal register file. It is the far end of the two-wire transactions issued by the board init masters (ADV7513 I2C, OV7670 SCCB).
- Used in simulation as a device model, and on hardware as a debug target on a spare bus.
- Decodes START, STOP and repeated START, matches a 7-bit device address, and supports an 8-bit sub-address pointer with auto-increment for burst writes and reads.
- Reports every accepted write as a one-cycle strobe.

---
 rtl/i2c_reg_target.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// I2C / SCCB target with an internal byte-wide register file.
// The bus is oversampled on clk. START, STOP and repeated START are decoded
// from synchronized SCL/SDA. A 7-bit device address is matched, then an 8-bit
// register pointer is loaded; the pointer auto-increments over burst writes
// and reads. Every accepted write is reported on wr_valid/wr_addr/wr_data.
module i2c_reg_target #(
  parameter logic [6:0] CHIP_ADDR = 7'h39,
  parameter int         REG_DEPTH = 256,
  parameter bit         SCCB_MODE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int PTR_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_DEV_ADDR = 4'd1;
  localparam logic [3:0] S_DEV_ACK  = 4'd2;
  localparam logic [3:0] S_SUB_ADDR = 4'd3;
  localparam logic [3:0] S_SUB_ACK  = 4'd4;
  localparam logic [3:0] S_WR_DATA  = 4'd5;
  localparam logic [3:0] S_WR_ACK   = 4'd6;
  localparam logic [3:0] S_RD_DATA  = 4'd7;
  localparam logic [3:0] S_RD_ACK   = 4'd8;

  logic             scl_s1, scl_s2, scl_d;
  logic             sda_s1, sda_s2, sda_d;
  logic             scl_rise, scl_fall, start_seen, stop_seen;
  logic [3:0]       state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       byte_in;
  logic [7:0]       rd_byte;
  logic [PTR_W-1:0] ptr;
  logic             rw;
  logic             sda_oe_q;
  logic             mem_we;
  logic [7:0]       regs [REG_DEPTH];

  // Two-flop synchronizers plus one history register for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Idle bus level is high; resetting to 1 avoids phantom edges.
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise   =  scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 &  scl_d;
  assign start_seen =  scl_s2 &  scl_d & sda_d & ~sda_s2;
  assign stop_seen  =  scl_s2 &  scl_d & ~sda_d & sda_s2;

  assign byte_in = {shreg[6:0], sda_s2};
  assign rd_byte = regs[ptr];
  assign mem_we  = scl_rise && (state == S_WR_DATA) && (bit_cnt == 4'd7);

  // NOTE: release is gated combinationally so SDA frees in the very cycle
  // reset is sampled, not one clock later when the flop clears.
  assign sda_oe = sda_oe_q & ~reset;

  // Bus protocol state machine: bit shifting, acks, pointer and write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      ptr      <= '0;
      rw       <= 1'b0;
      sda_oe_q <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
    end else begin
      // NOTE: this default is overridden by a later non-blocking assignment
      // in the same cycle, which is how the single-cycle strobe is formed.
      wr_valid <= 1'b0;
      if (start_seen) begin
        state    <= S_DEV_ADDR;
        bit_cnt  <= 4'd0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else if (stop_seen) begin
        state    <= S_IDLE;
        bit_cnt  <= 4'd0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_DEV_ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (byte_in[7:1] == CHIP_ADDR) begin
                  rw    <= byte_in[0];
                  state <= S_DEV_ACK;
                end else begin
                  state <= S_IDLE;
                end
              end
            end
          end
          // Ack slot: pull low on the fall ending bit 8, release on the next.
          S_DEV_ACK, S_SUB_ACK, S_WR_ACK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd1;
            end else if (scl_fall && bit_cnt == 4'd0) begin
              sda_oe_q <= 1'b1;
              if (state == S_DEV_ACK) busy <= 1'b1;
            end else if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (state == S_DEV_ACK && rw) begin
                sda_oe_q <= ~rd_byte[7];
                shreg    <= {rd_byte[6:0], 1'b0};
                state    <= S_RD_DATA;
              end else if (state == S_DEV_ACK) begin
                sda_oe_q <= 1'b0;
                state    <= S_SUB_ADDR;
              end else begin
                sda_oe_q <= 1'b0;
                state    <= S_WR_DATA;
                if (state == S_WR_ACK) ptr <= ptr + PTR_ONE;
              end
            end
          end
          S_SUB_ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                ptr     <= byte_in[PTR_W-1:0];
                state   <= S_SUB_ACK;
              end
            end
          end
          S_WR_DATA: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt  <= 4'd0;
                wr_valid <= 1'b1;
                wr_addr  <= 8'(ptr);
                wr_data  <= byte_in;
                state    <= S_WR_ACK;
              end
            end
          end
          // First bit was placed when entering; the rest follow each fall.
          S_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe_q <= 1'b0;
                bit_cnt  <= 4'd0;
                state    <= S_RD_ACK;
              end else begin
                sda_oe_q <= ~shreg[7];
                shreg    <= {shreg[6:0], 1'b0};
              end
            end
          end
          // Master ack slot: ACK continues the burst, NACK ends it.
          S_RD_ACK: begin
            if (scl_rise) begin
              if (SCCB_MODE || sda_s2) begin
                state <= S_IDLE;
              end else begin
                ptr     <= ptr + PTR_ONE;
                bit_cnt <= 4'd1;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt  <= 4'd0;
              sda_oe_q <= ~rd_byte[7];
              shreg    <= {rd_byte[6:0], 1'b0};
              state    <= S_RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Register file storage, written on the 8th data bit of each write byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is reset deliberately because registers must read
      // back as zero after reset; this rules out a RAM macro here.
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= 8'h00;
    end else if (mem_we) begin
      regs[ptr] <= byte_in;
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Self-checking bench for i2c_reg_target: a bit-level bus master, a
// register-file/pointer reference model, directed scenarios and random traffic.
module tb_i2c_reg_target;

  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        m_sda;
  logic        sda_bus;
  logic        oe0, wr_valid0, busy0;
  logic [7:0]  wr_addr0, wr_data0;
  logic        oe1, wr_valid1, busy1;
  logic [7:0]  wr_addr1, wr_data1;

  assign sda_bus = m_sda & ~oe0 & ~oe1;

  always #5 clk = ~clk;

  i2c_reg_target #(.CHIP_ADDR(7'h39), .REG_DEPTH(256), .SCCB_MODE(1'b0)) u_dut (
    .clk(clk), .reset(reset), .scl(scl), .sda_i(sda_bus), .sda_oe(oe0),
    .wr_valid(wr_valid0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0)
  );

  i2c_reg_target #(.CHIP_ADDR(7'h21), .REG_DEPTH(16), .SCCB_MODE(1'b1)) u_sccb (
    .clk(clk), .reset(reset), .scl(scl), .sda_i(sda_bus), .sda_oe(oe1),
    .wr_valid(wr_valid1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_ptr;
  logic [15:0] exp_wr [$];
  logic [15:0] got_wr [$];
  logic [15:0] got_wr1 [$];
  logic [7:0]  wbuf [$];
  int          oe_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture write strobes and any SDA drive, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (wr_valid0) got_wr.push_back({wr_addr0, wr_data0});
    if (wr_valid1) got_wr1.push_back({wr_addr1, wr_data1});
    if (oe0 || oe1) oe_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL cycle: entered and left with SCL low.
  task automatic bit_xfer(input logic b, output logic r);
    wait_clk(Q); m_sda = b;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); r = sda_bus;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic start_bus();
    if (scl == 1'b0) begin
      m_sda = 1'b1; wait_clk(Q);
      scl = 1'b1;   wait_clk(Q);
    end
    m_sda = 1'b0; wait_clk(2 * Q);
    scl = 1'b0;
  endtask

  // STOP; optionally checks busy is still high 2 clk later and low 3 clk later.
  task automatic stop_bus(input bit chk_busy);
    wait_clk(Q); m_sda = 1'b0;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); m_sda = 1'b1;
    if (chk_busy) begin
      wait_clk(2); check("busy_before_stop", busy0, 1'b1);
      wait_clk(1); check("busy_after_stop", busy0, 1'b0);
      wait_clk(2 * Q - 3);
    end else begin
      wait_clk(2 * Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, ack_n);
  endtask

  task automatic send_byte(input logic [7:0] d, input string tag);
    logic a;
    write_byte(d, a);
    check(tag, a, 1'b0);
  endtask

  task automatic read_byte(input logic m_ack_n, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
    bit_xfer(m_ack_n, r);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_cnt"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check({tag, "_wr"}, got_wr[i], exp_wr[i]);
    got_wr.delete();
    exp_wr.delete();
  endtask

  // Burst write of wbuf starting at sub; model updates memory and pointer.
  task automatic tx_write(input logic [7:0] sub, input string tag);
    logic [7:0] p;
    start_bus();
    send_byte(8'h72, {tag, "_dev_ack"});
    send_byte(sub, {tag, "_sub_ack"});
    p = sub;
    foreach (wbuf[i]) begin
      send_byte(wbuf[i], {tag, "_data_ack"});
      ref_mem[p] = wbuf[i];
      exp_wr.push_back({p, wbuf[i]});
      p = p + 8'd1;
    end
    ref_ptr = p;
    stop_bus(1'b1);
    compare_writes(tag);
  endtask

  // Read len bytes (ACK all but the last), optionally after setting the pointer.
  task automatic tx_read(input logic [7:0] sub, input bit use_sub, input int len, input string tag);
    logic [7:0] d;
    if (use_sub) begin
      start_bus();
      send_byte(8'h72, {tag, "_dev_ack"});
      send_byte(sub, {tag, "_sub_ack"});
      ref_ptr = sub;
    end
    start_bus();
    send_byte(8'h73, {tag, "_rd_dev_ack"});
    for (int i = 0; i < len; i++) begin
      read_byte((i == len - 1) ? 1'b1 : 1'b0, d);
      check({tag, "_rd_data"}, d, ref_mem[ref_ptr]);
      if (i != len - 1) ref_ptr = ref_ptr + 8'd1;
    end
    check({tag, "_rd_release"}, oe0, 1'b0);
    stop_bus(1'b1);
    compare_writes(tag);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         kind, len;
    logic [7:0] sub;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_ptr = 8'h00;
    reset = 1'b1; scl = 1'b1; m_sda = 1'b1;
    wait_clk(5);
    check("rst_sda_oe", oe0, 1'b0);
    check("rst_wr_valid", wr_valid0, 1'b0);
    check("rst_wr_addr", wr_addr0, 8'h00);
    check("rst_wr_data", wr_data0, 8'h00);
    check("rst_busy", busy0, 1'b0);
    check("rst_sccb_oe", oe1, 1'b0);
    reset = 1'b0;
    wait_clk(5);

    // Write burst 0x10: A5, 5A.
    wbuf = '{8'hA5, 8'h5A};
    tx_write(8'h10, "burst");

    // Combined read of the same two bytes.
    tx_read(8'h10, 1'b1, 2, "combined");

    // Address mismatch: no ack, no drive, no write, not busy.
    oe_cnt = 0;
    start_bus();
    write_byte(8'h74, a); check("nomatch_dev_nak", a, 1'b1);
    write_byte(8'h10, a); check("nomatch_sub_nak", a, 1'b1);
    check("nomatch_busy", busy0, 1'b0);
    write_byte(8'hFF, a); check("nomatch_data_nak", a, 1'b1);
    stop_bus(1'b0);
    check("nomatch_oe_cnt", oe_cnt, 0);
    compare_writes("nomatch");

    // Pointer wrap 0xFF -> 0x00, then read back 0x00.
    wbuf = '{8'h11, 8'h22};
    tx_write(8'hFF, "wrap");
    tx_read(8'h00, 1'b1, 1, "wrap_rb");

    // Partial byte aborted by STOP: no write, pointer stays at sub.
    start_bus();
    send_byte(8'h72, "abort_dev_ack");
    send_byte(8'h30, "abort_sub_ack");
    ref_ptr = 8'h30;
    for (int i = 0; i < 4; i++) bit_xfer(1'b0, a);
    stop_bus(1'b0);
    compare_writes("abort");
    tx_read(8'h00, 1'b0, 1, "abort_cur");

    // Random traffic around the 0xFF/0x00 boundary.
    for (int t = 0; t < 22; t++) begin
      kind = $urandom_range(0, 2);
      sub  = 8'($urandom_range(250, 261));
      len  = $urandom_range(1, 3);
      if (kind == 0) begin
        wbuf.delete();
        for (int i = 0; i < len; i++) wbuf.push_back(8'($urandom));
        tx_write(sub, "rnd_w");
      end else if (kind == 1) begin
        tx_read(sub, 1'b1, len, "rnd_r");
      end else begin
        tx_read(8'h00, 1'b0, len, "rnd_cur");
      end
    end

    // Reset while the target is pulling SDA low in a read.
    wbuf = '{8'h3C};
    tx_write(8'h40, "pre_rst");
    start_bus();
    send_byte(8'h72, "rst_dev_ack");
    send_byte(8'h40, "rst_sub_ack");
    start_bus();
    send_byte(8'h73, "rst_rd_dev_ack");
    for (int k = 0; k < 40 && !oe0; k++) wait_clk(1);
    check("rst_target_drives", oe0, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_oe_same_cycle", oe0, 1'b0);
    wait_clk(1);
    check("rst_oe_after_edge", oe0, 1'b0);
    check("rst_busy_cleared", busy0, 1'b0);
    wait_clk(2);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_ptr = 8'h00;
    got_wr.delete(); got_wr1.delete(); exp_wr.delete();
    stop_bus(1'b0);
    tx_read(8'h40, 1'b1, 2, "rst_rb40");
    tx_read(8'h10, 1'b1, 2, "rst_rb10");
    tx_read(8'hFF, 1'b1, 2, "rst_rbff");

    // SCCB-mode target at 0x21 with 16 registers.
    start_bus();
    send_byte(8'h42, "sccb_dev_ack");
    send_byte(8'h15, "sccb_sub_ack");
    send_byte(8'h3C, "sccb_data_ack");
    stop_bus(1'b0);
    check("sccb_wr_cnt", got_wr1.size(), 1);
    if (got_wr1.size() > 0) check("sccb_wr", got_wr1[0], 16'h053C);
    got_wr1.delete();
    start_bus();
    send_byte(8'h42, "sccb_rd_dev_ack");
    send_byte(8'h05, "sccb_rd_sub_ack");
    start_bus();
    send_byte(8'h43, "sccb_rd_dev2_ack");
    read_byte(1'b0, d);
    check("sccb_rd_data", d, 8'h3C);
    read_byte(1'b1, d);
    check("sccb_released", d, 8'hFF);
    stop_bus(1'b0);
    start_bus();
    send_byte(8'h43, "sccb_cur_dev_ack");
    read_byte(1'b1, d);
    check("sccb_cur_data", d, 8'h3C);
    check("sccb_cur_release", oe1, 1'b0);
    stop_bus(1'b0);
    start_bus();
    send_byte(8'h42, "sccb_w2_dev_ack");
    send_byte(8'h06, "sccb_w2_sub_ack");
    send_byte(8'h77, "sccb_w2_data_ack");
    stop_bus(1'b0);
    check("sccb_w2_cnt", got_wr1.size(), 1);
    if (got_wr1.size() > 0) check("sccb_w2", got_wr1[0], 16'h0677);
    compare_writes("sccb_main_quiet");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
